// File: rtl/sum_of_squares_seq.sv
// Sequential sum of squares: latches (x, y) on start and computes x*x + y*y
// with a single shift-add accumulator, one multiplier bit per clock.
module sum_of_squares_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH:0]     sum_sq
);

    localparam int OUT_W = 2 * WIDTH + 1;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_X = 2'd1,
        MUL_Y = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   xa;
    logic [WIDTH-1:0]   ya;
    logic [OUT_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   mul_op;
    logic [OUT_W-1:0]   addend;
    logic [OUT_W-1:0]   acc_next;
    logic               last_bit;

    // The same operand feeds both multiplicand and multiplier, so one shifted copy suffices.
    assign mul_op   = (state == MUL_X) ? xa : ya;
    assign addend   = mul_op[cnt] ? (OUT_W'(mul_op) << cnt) : '0;
    assign acc_next = acc + addend;
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = MUL_X;
            MUL_X:   if (last_bit) next_state = MUL_Y;
            MUL_Y:   if (last_bit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xa     <= '0;
            ya     <= '0;
            acc    <= '0;
            cnt    <= '0;
            sum_sq <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        xa  <= x;
                        ya  <= y;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                MUL_X: begin
                    acc <= acc_next;
                    cnt <= last_bit ? '0 : cnt + 1'b1;
                end
                MUL_Y: begin
                    acc <= acc_next;
                    cnt <= last_bit ? '0 : cnt + 1'b1;
                    if (last_bit) begin
                        sum_sq <= acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
